// File: rtl/pspin_cfg_pkg.sv
// Command-ID and command-response types shared by the cluster command path.
package pspin_cfg_pkg;

   localparam int unsigned C_CLUSTER_ID_WIDTH = 8;
   localparam int unsigned C_CORE_ID_WIDTH    = 4;
   localparam int unsigned C_LOCAL_ID_WIDTH   = 4;

   typedef struct packed {
      logic [C_CLUSTER_ID_WIDTH-1:0] cluster_id;
      logic [C_CORE_ID_WIDTH-1:0]    core_id;
      logic [C_LOCAL_ID_WIDTH-1:0]   local_id;
   } pspin_cmd_id_t;

   typedef struct packed {
      pspin_cmd_id_t cmd_id;
      logic          error;
      logic [14:0]   status;
   } pspin_cmd_resp_t;

endpackage

// File: rtl/cluster_cmd_resp_fifo.sv
// Single-clock FIFO, no fall-through: a push is visible at the head next cycle.
// Full blocks pushes even when a pop happens in the same cycle; empty head reads as zero.
module cluster_cmd_resp_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter type         T     = logic
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   T              mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/cluster_cmd_resp.sv
// Demuxes uncluster command responses into per-core FIFOs; 1-cycle latency, ready drops only on a full target FIFO.
// CLUSTER_CMD_RESP_CHECK_EN builds outstanding-command accounting and sticky error flags.
module cluster_cmd_resp
   import pspin_cfg_pkg::*;
#(
   parameter int unsigned NUM_CORES       = 8,
   parameter int unsigned FIFO_DEPTH      = 2,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 cmd_resp_valid_i,
   output logic                                 cmd_resp_ready_o,
   input  pspin_cmd_resp_t                      cmd_resp_i,
   output logic            [NUM_CORES-1:0]      cmd_resp_valid_o,
   input  logic            [NUM_CORES-1:0]      cmd_resp_ready_i,
   output pspin_cmd_resp_t [NUM_CORES-1:0]      cmd_resp_o,
   input  logic            [NUM_CORES-1:0]      cmd_issued_i,
   output logic                                 err_o,
   output logic            [NUM_CORES-1:0]      err_core_o
);

   logic [NUM_CORES-1:0]       full, empty, push, pop;
   logic [C_CORE_ID_WIDTH-1:0] tgt;
   logic                       tgt_full;

   assign tgt = cmd_resp_i.cmd_id.core_id;

   // Out-of-range targets match no core, so they are always accepted and dropped.
   always_comb begin
      tgt_full = 1'b0;
      push     = '0;
      for (int c = 0; c < int'(NUM_CORES); c++) begin
         if (tgt == C_CORE_ID_WIDTH'(c)) begin
            tgt_full = full[c];
            push[c]  = cmd_resp_valid_i & ~full[c];
         end
      end
   end

   assign cmd_resp_ready_o = ~tgt_full;
   assign cmd_resp_valid_o = ~empty;
   assign pop              = cmd_resp_valid_o & cmd_resp_ready_i;

   for (genvar c = 0; c < NUM_CORES; c++) begin : g_fifo
      cluster_cmd_resp_fifo #(
         .DEPTH (FIFO_DEPTH),
         .T     (pspin_cmd_resp_t)
      ) i_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (push[c]),
         .data_i  (cmd_resp_i),
         .pop_i   (pop[c]),
         .data_o  (cmd_resp_o[c]),
         .full_o  (full[c]),
         .empty_o (empty[c])
      );
   end

`ifdef CLUSTER_CMD_RESP_CHECK_EN
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

   logic [NUM_CORES-1:0][OW-1:0] out_cnt_q, out_cnt_d;
   logic [NUM_CORES-1:0]         err_core_q, err_core_d;
   logic                         err_q, err_d, in_range;

   assign in_range = (32'(tgt) < NUM_CORES);

   // Issue and push in the same cycle cancel, so neither error case can fire then.
   always_comb begin
      out_cnt_d  = out_cnt_q;
      err_core_d = err_core_q;
      for (int c = 0; c < int'(NUM_CORES); c++) begin
         case ({cmd_issued_i[c], push[c]})
            2'b10: begin
               if (out_cnt_q[c] == OW'(MAX_OUTSTANDING)) err_core_d[c] = 1'b1;
               else                                     out_cnt_d[c]  = out_cnt_q[c] + OW'(1);
            end
            2'b01: begin
               if (out_cnt_q[c] == '0) err_core_d[c] = 1'b1;
               else                    out_cnt_d[c]  = out_cnt_q[c] - OW'(1);
            end
            default: ;
         endcase
      end
      err_d = err_q | (cmd_resp_valid_i & ~in_range) | (|err_core_d);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_cnt_q  <= '0;
         err_core_q <= '0;
         err_q      <= 1'b0;
      end else begin
         out_cnt_q  <= out_cnt_d;
         err_core_q <= err_core_d;
         err_q      <= err_d;
      end
   end

   assign err_o      = err_q;
   assign err_core_o = err_core_q;
`else
   logic unused_issued;
   assign unused_issued = ^cmd_issued_i;
   assign err_o         = 1'b0;
   assign err_core_o    = '0;
`endif

endmodule

// File: tb/tb_cluster_cmd_resp.sv
// Directed bench for cluster_cmd_resp: routing, backpressure, streaming, drop, accounting, reset.
module tb_cluster_cmd_resp;
   import pspin_cfg_pkg::*;

   localparam int NC = 8;
`ifdef CLUSTER_CMD_RESP_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         resp_vld_i, resp_rdy_o;
   pspin_cmd_resp_t              resp_i;
   logic            [NC-1:0]     vld_o, rdy_i, issued;
   pspin_cmd_resp_t [NC-1:0]     resp_o;
   logic                         err_o;
   logic            [NC-1:0]     err_core_o;
   int                           total = 0;
   int                           bad   = 0;

   always #5 clk = ~clk;

   cluster_cmd_resp #(
      .NUM_CORES       (NC),
      .FIFO_DEPTH      (2),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .cmd_resp_valid_i (resp_vld_i),
      .cmd_resp_ready_o (resp_rdy_o),
      .cmd_resp_i       (resp_i),
      .cmd_resp_valid_o (vld_o),
      .cmd_resp_ready_i (rdy_i),
      .cmd_resp_o       (resp_o),
      .cmd_issued_i     (issued),
      .err_o            (err_o),
      .err_core_o       (err_core_o)
   );

   function automatic pspin_cmd_resp_t mk(input logic [3:0] core, input logic [14:0] st);
      pspin_cmd_resp_t r;
      r                   = '0;
      r.cmd_id.cluster_id = 8'h2A;
      r.cmd_id.core_id    = core;
      r.cmd_id.local_id   = st[3:0];
      r.error             = st[0];
      r.status            = st;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [NC-1:0] mask);
      issued = mask;
      tick();
      issued = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; resp_vld_i = 1'b0; resp_i = '0; rdy_i = '0; issued = '0;
      #2;
      total++; if (vld_o !== '0) begin bad++; $display("FAIL reset_valid got=%b exp=%b", vld_o, 8'b0); end
      total++; if (resp_rdy_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", resp_rdy_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
      total++; if (err_core_o !== '0) begin bad++; $display("FAIL reset_err_core got=%b exp=0", err_core_o); end
      total++; if (resp_o !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", resp_o); end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      pspin_cmd_resp_t exp;
      exp = mk(4'd3, 15'h1234);
      issue(8'b0000_1000);
      resp_i = exp; resp_vld_i = 1'b1;
      #1;
      total++; if (resp_rdy_o !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", resp_rdy_o); end
      total++; if (vld_o !== '0) begin bad++; $display("FAIL single_no_fallthrough got=%b exp=0", vld_o); end
      tick();
      resp_vld_i = 1'b0;
      total++; if (vld_o !== 8'b0000_1000) begin bad++; $display("FAIL single_valid got=%b exp=00001000", vld_o); end
      total++; if (resp_o[3] !== exp) begin bad++; $display("FAIL single_data got=%h exp=%h", resp_o[3], exp); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", err_o); end
      rdy_i[3] = 1'b1;
      tick();
      rdy_i = '0;
      total++; if (vld_o !== '0) begin bad++; $display("FAIL single_popped got=%b exp=0", vld_o); end
   endtask

   task automatic test_backpressure();
      pspin_cmd_resp_t a, b, c, d;
      a = mk(4'd5, 15'h0A); b = mk(4'd5, 15'h0B); c = mk(4'd5, 15'h0C); d = mk(4'd2, 15'h0D);
      issue(8'b0010_0100);
      issue(8'b0010_0000);
      issue(8'b0010_0000);
      resp_vld_i = 1'b1; resp_i = a;
      tick();
      resp_i = b;
      tick();
      resp_i = c;
      #1;
      total++; if (resp_rdy_o !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", resp_rdy_o); end
      tick();
      total++; if (resp_o[5] !== a) begin bad++; $display("FAIL bp_head_held got=%h exp=%h", resp_o[5], a); end
      resp_i = d;
      #1;
      total++; if (resp_rdy_o !== 1'b1) begin bad++; $display("FAIL bp_other_ready got=%b exp=1", resp_rdy_o); end
      tick();
      resp_vld_i = 1'b0;
      total++; if (vld_o !== 8'b0010_0100) begin bad++; $display("FAIL bp_valids got=%b exp=00100100", vld_o); end
      total++; if (resp_o[2] !== d) begin bad++; $display("FAIL bp_core2_data got=%h exp=%h", resp_o[2], d); end
      rdy_i = 8'b0010_0100;
      tick();
      total++; if (resp_o[5] !== b) begin bad++; $display("FAIL bp_drain_order got=%h exp=%h", resp_o[5], b); end
      total++; if (vld_o !== 8'b0010_0000) begin bad++; $display("FAIL bp_drain_valid got=%b exp=00100000", vld_o); end
      tick();
      rdy_i = '0;
      total++; if (vld_o !== '0) begin bad++; $display("FAIL bp_drained got=%b exp=0", vld_o); end
   endtask

   task automatic test_back_to_back();
      pspin_cmd_resp_t exp;
      rdy_i[0] = 1'b1; resp_vld_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         exp = mk(4'd0, 15'(256 + i));
         resp_i = exp; issued = 8'b0000_0001;
         #1;
         total++; if (resp_rdy_o !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, resp_rdy_o); end
         tick();
         total++;
         if ({vld_o[0], resp_o[0]} !== {1'b1, exp}) begin
            bad++; $display("FAIL b2b_data[%0d] got=%b/%h exp=1/%h", i, vld_o[0], resp_o[0], exp);
         end
      end
      resp_vld_i = 1'b0; issued = '0;
      tick();
      rdy_i = '0;
      total++; if (vld_o !== '0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", vld_o); end
      total++; if (err_core_o !== '0) begin bad++; $display("FAIL b2b_err_core got=%b exp=0", err_core_o); end
   endtask

   task automatic test_out_of_range();
      resp_i = mk(4'd9, 15'h99); resp_vld_i = 1'b1;
      #1;
      total++; if (resp_rdy_o !== 1'b1) begin bad++; $display("FAIL oor_ready got=%b exp=1", resp_rdy_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL oor_err_before got=%b exp=0", err_o); end
      tick();
      resp_vld_i = 1'b0;
      total++; if (vld_o !== '0) begin bad++; $display("FAIL oor_dropped got=%b exp=0", vld_o); end
      total++; if (err_o !== CHK) begin bad++; $display("FAIL oor_err got=%b exp=%b", err_o, CHK); end
      total++; if (err_core_o !== '0) begin bad++; $display("FAIL oor_err_core got=%b exp=0", err_core_o); end
   endtask

   task automatic test_outstanding();
      pspin_cmd_resp_t second;
      second = mk(4'd1, 15'h52);
      rdy_i[1] = 1'b1;
      resp_i = mk(4'd1, 15'h51); resp_vld_i = 1'b1; issued = 8'b0000_0010;
      tick();
      issued = '0;
      total++; if (err_core_o !== '0) begin bad++; $display("FAIL outst_same_cycle got=%b exp=0", err_core_o); end
      resp_i = second;
      tick();
      resp_vld_i = 1'b0;
      total++; if (err_core_o !== {6'b0, CHK, 1'b0}) begin bad++; $display("FAIL outst_underflow got=%b exp=%b", err_core_o, {6'b0, CHK, 1'b0}); end
      total++; if ({vld_o[1], resp_o[1]} !== {1'b1, second}) begin bad++; $display("FAIL outst_delivered got=%b/%h exp=1/%h", vld_o[1], resp_o[1], second); end
      tick();
      rdy_i = '0;
      total++; if (err_o !== CHK) begin bad++; $display("FAIL outst_err got=%b exp=%b", err_o, CHK); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 4; i++) issue(8'b1000_0000);
      total++; if (err_core_o[7] !== 1'b0) begin bad++; $display("FAIL sat_at_max got=%b exp=0", err_core_o[7]); end
      issue(8'b1000_0000);
      total++; if (err_core_o[7] !== CHK) begin bad++; $display("FAIL sat_overflow got=%b exp=%b", err_core_o[7], CHK); end
   endtask

   task automatic test_reset_mid();
      issue(8'b0101_0000);
      resp_i = mk(4'd4, 15'h44); resp_vld_i = 1'b1;
      tick();
      resp_i = mk(4'd6, 15'h66);
      tick();
      resp_vld_i = 1'b0;
      total++; if (vld_o !== 8'b0101_0000) begin bad++; $display("FAIL rstmid_filled got=%b exp=01010000", vld_o); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (vld_o !== '0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", vld_o); end
      total++; if (resp_o !== '0) begin bad++; $display("FAIL rstmid_data got=%h exp=0", resp_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b exp=0", err_o); end
      total++; if (err_core_o !== '0) begin bad++; $display("FAIL rstmid_err_core got=%b exp=0", err_core_o); end
      #2;
      rst = 1'b0;
      resp_i = mk(4'd4, 15'h45);
      #1;
      total++; if (resp_rdy_o !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", resp_rdy_o); end
      tick();
      total++; if (vld_o !== '0) begin bad++; $display("FAIL rstmid_after got=%b exp=0", vld_o); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_out_of_range();
      test_outstanding();
      test_saturation();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
